snake_body_tracker: RTL and testbench

- Sits directly downstream of the snake head-motion stage. Consumes each new head position (new_xpos/new_ypos) as a head_valid pulse.
- Keeps the snake body as a ring buffer of the last N head positions and grows it on request.
- Detects self-collision with a multi-cycle sequential scan.
- Gives the OLED renderer a registered random-access read port over the body segments, all on slow_clk.

---
 rtl/snake_body_tracker.sv | 139 +++++++++++++
 tb/tb_snake_body_tracker.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body_tracker.sv
// Snake body ring buffer with a multi-cycle self-collision scan and a registered read port.
// Optional SNAKE_BOUNDS_CHECK_EN treats out-of-field heads as collisions.
module snake_body_tracker #(
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 3,
  parameter int START_X  = 47,
  parameter int START_Y  = 31,
  parameter int MAX_X    = 95,
  parameter int MAX_Y    = 63
) (
  input  logic                       slow_clk,
  input  logic                       reset,
  input  logic                       head_valid,
  input  logic [9:0]                 head_x,
  input  logic [9:0]                 head_y,
  input  logic                       grow,
  input  logic [$clog2(MAX_LEN)-1:0] rd_idx,
  output logic [9:0]                 rd_x,
  output logic [9:0]                 rd_y,
  output logic                       rd_valid,
  output logic [$clog2(MAX_LEN):0]   length,
  output logic                       busy,
  output logic                       update_done,
  output logic                       collision,
  output logic                       overrun
);

  localparam int IW = $clog2(MAX_LEN);
  localparam int LW = IW + 1;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } pos_t;

  typedef enum logic [1:0] {IDLE, CHECK, WRITE} state_t;

  localparam pos_t START = '{x: 10'(START_X), y: 10'(START_Y)};

  pos_t            body [MAX_LEN];
  pos_t            seg0;
  pos_t            head_q;
  pos_t            head_in;
  pos_t            k_seg;
  pos_t            rd_seg;
  logic [IW-1:0]   hp;
  logic [IW-1:0]   k;
  logic            grow_pending;
  logic            match;
  logic            last;
  logic            hit;
  logic            no_move;
  logic            oob;
  state_t          state;

  assign head_in = '{x: head_x, y: head_y};
  assign k_seg   = body[hp - k];
  assign rd_seg  = body[hp - rd_idx];
  assign last    = ({1'b0, k} == (length - LW'(1)));
  // The tail only counts when this move grows; otherwise it vacates as the head arrives.
  assign hit     = (k_seg == head_q) && (!last || grow_pending);
  assign no_move = (head_in == seg0);

`ifdef SNAKE_BOUNDS_CHECK_EN
  assign oob = (head_x > 10'(MAX_X)) || (head_y > 10'(MAX_Y));
`else
  // Bounds are parameters of both builds; the term is constant-false here.
  assign oob = 1'b0 & ((head_x > 10'(MAX_X)) | (head_y > 10'(MAX_Y)));
`endif

  always_ff @(posedge slow_clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_LEN; i++) body[i] <= START;
      seg0         <= START;
      head_q       <= START;
      hp           <= '0;
      k            <= '0;
      length       <= LW'(INIT_LEN);
      grow_pending <= 1'b0;
      match        <= 1'b0;
      state        <= IDLE;
      busy         <= 1'b0;
      update_done  <= 1'b0;
      collision    <= 1'b0;
      overrun      <= 1'b0;
      rd_x         <= '0;
      rd_y         <= '0;
      rd_valid     <= 1'b0;
    end else begin
      update_done <= 1'b0;
      rd_x        <= rd_seg.x;
      rd_y        <= rd_seg.y;
      rd_valid    <= ({1'b0, rd_idx} < length);
      if (grow) grow_pending <= 1'b1;
      if (head_valid && state != IDLE) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (head_valid && !collision) begin
            if (no_move) begin
              update_done <= 1'b1;
            end else if (oob) begin
              collision   <= 1'b1;
              update_done <= 1'b1;
            end else begin
              head_q <= head_in;
              k      <= IW'(1);
              match  <= 1'b0;
              busy   <= 1'b1;
              state  <= CHECK;
            end
          end
        end
        CHECK: begin
          match <= match | hit;
          k     <= k + IW'(1);
          if (last) state <= WRITE;
        end
        WRITE: begin
          if (!match) begin
            hp                  <= hp + IW'(1);
            body[hp + IW'(1)]   <= head_q;
            seg0                <= head_q;
            if (grow_pending && length < LW'(MAX_LEN)) length <= length + LW'(1);
            // A grow landing on this very edge survives for the next move.
            grow_pending        <= grow;
          end else begin
            collision <= 1'b1;
          end
          update_done <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_body_tracker.sv
// Directed bench for snake_body_tracker with MAX_LEN=8, INIT_LEN=3.
module tb_snake_body_tracker;

  logic       slow_clk = 1'b0;
  logic       reset = 1'b1;
  logic       head_valid = 1'b0;
  logic [9:0] head_x = '0;
  logic [9:0] head_y = '0;
  logic       grow = 1'b0;
  logic [2:0] rd_idx = '0;
  logic [9:0] rd_x, rd_y;
  logic       rd_valid;
  logic [3:0] length;
  logic       busy, update_done, collision, overrun;

  int n_checks = 0;
  int n_fail   = 0;

  snake_body_tracker #(.MAX_LEN(8), .INIT_LEN(3)) dut (
    .slow_clk(slow_clk), .reset(reset), .head_valid(head_valid),
    .head_x(head_x), .head_y(head_y), .grow(grow), .rd_idx(rd_idx),
    .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid), .length(length),
    .busy(busy), .update_done(update_done), .collision(collision),
    .overrun(overrun)
  );

  always #5 slow_clk = ~slow_clk;

  task automatic tick();
    @(posedge slow_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_grow();
    grow = 1'b1;
    tick();
    grow = 1'b0;
  endtask

  task automatic seg(input string tag, input logic [2:0] idx, input logic [9:0] ex, input logic [9:0] ey);
    rd_idx = idx;
    tick();
    chk({tag, "_x"}, rd_x, ex);
    chk({tag, "_y"}, rd_y, ey);
    chk({tag, "_v"}, rd_valid, 1);
  endtask

  // Present one head and wait (bounded) for update_done; count busy cycles seen.
  task automatic move(input logic [9:0] x, input logic [9:0] y, output int busy_n, output bit done);
    head_valid = 1'b1;
    head_x = x;
    head_y = y;
    tick();
    head_valid = 1'b0;
    busy_n = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (busy) busy_n++;
      if (update_done) done = 1'b1;
      else tick();
    end
  endtask

  initial begin
    int  bn;
    bit  dn;
    bit  seen;

    // 1. reset state and initial read sweep
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", update_done, 0);
    chk("rst_coll", collision, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_rdv", rd_valid, 0);
    chk("rst_rdx", rd_x, 0);
    chk("rst_len", length, 3);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_idx = 3'(i);
      tick();
      chk("sweep_v", rd_valid, (i < 3) ? 1 : 0);
      if (i < 3) begin
        chk("sweep_x", rd_x, 47);
        chk("sweep_y", rd_y, 31);
      end
    end

    // 2. plain move
    move(10'd48, 10'd31, bn, dn);
    chk("mv_done", dn, 1);
    chk("mv_busy", bn, 3);
    tick();
    chk("mv_pulse1", update_done, 0);
    chk("mv_len", length, 3);
    seg("mv_s0", 3'd0, 10'd48, 10'd31);
    seg("mv_s1", 3'd1, 10'd47, 10'd31);

    // 3. grow up to MAX_LEN, then saturate
    pulse_grow();
    move(10'd49, 10'd31, bn, dn);
    chk("g_done", dn, 1);
    chk("g_len", length, 4);
    seg("g_s0", 3'd0, 10'd49, 10'd31);
    seg("g_s3", 3'd3, 10'd47, 10'd31);
    rd_idx = 3'd4;
    tick();
    chk("g_s4_v", rd_valid, 0);
    for (int i = 0; i < 4; i++) begin
      pulse_grow();
      move(10'(50 + i), 10'd31, bn, dn);
      chk("gl_done", dn, 1);
      chk("gl_busy", bn, 4 + i);
      chk("gl_len", length, 5 + i);
    end
    pulse_grow();
    move(10'd54, 10'd31, bn, dn);
    chk("sat_busy", bn, 8);
    chk("sat_len", length, 8);
    // tail (47,31) vacates unless a stale grow survived the saturated move
    move(10'd47, 10'd31, bn, dn);
    chk("sat_done", dn, 1);
    chk("sat_coll", collision, 0);
    chk("sat_len2", length, 8);
    seg("sat_s0", 3'd0, 10'd47, 10'd31);
    seg("sat_s7", 3'd7, 10'd48, 10'd31);

    // 4. no-move keeps pending grow
    do_reset();
    pulse_grow();
    move(10'd47, 10'd31, bn, dn);
    chk("nm_done", dn, 1);
    chk("nm_busy", bn, 0);
    chk("nm_len", length, 3);
    seg("nm_s0", 3'd0, 10'd47, 10'd31);
    move(10'd48, 10'd31, bn, dn);
    chk("nm_grow_len", length, 4);

    // 5a. tail without grow is safe
    do_reset();
    move(10'd48, 10'd31, bn, dn);
    move(10'd48, 10'd32, bn, dn);
    move(10'd47, 10'd32, bn, dn);
    move(10'd48, 10'd31, bn, dn);
    chk("tail_done", dn, 1);
    chk("tail_coll", collision, 0);
    chk("tail_len", length, 3);
    seg("tail_s0", 3'd0, 10'd48, 10'd31);

    // 5b. tail with grow collides
    do_reset();
    move(10'd48, 10'd31, bn, dn);
    move(10'd48, 10'd32, bn, dn);
    move(10'd47, 10'd32, bn, dn);
    pulse_grow();
    move(10'd48, 10'd31, bn, dn);
    chk("tailg_done", dn, 1);
    chk("tailg_busy", bn, 3);
    chk("tailg_coll", collision, 1);
    chk("tailg_len", length, 3);
    seg("tailg_s0", 3'd0, 10'd47, 10'd32);

    // 5c. mid-body hit, then the game is frozen
    do_reset();
    pulse_grow();
    move(10'd48, 10'd31, bn, dn);
    pulse_grow();
    move(10'd48, 10'd32, bn, dn);
    move(10'd49, 10'd32, bn, dn);
    move(10'd49, 10'd33, bn, dn);
    move(10'd48, 10'd33, bn, dn);
    chk("mid_len5", length, 5);
    seg("mid_s3", 3'd3, 10'd48, 10'd32);
    move(10'd48, 10'd32, bn, dn);
    chk("mid_busy", bn, 5);
    chk("mid_coll", collision, 1);
    chk("mid_len", length, 5);
    head_valid = 1'b1;
    head_x = 10'd50;
    head_y = 10'd50;
    tick();
    head_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen |= update_done | busy;
      tick();
    end
    chk("frozen", seen, 0);
    chk("frozen_ovr", overrun, 0);

    // 6. head_valid while busy is dropped
    do_reset();
    head_valid = 1'b1;
    head_x = 10'd48;
    head_y = 10'd31;
    tick();
    head_x = 10'd49;
    tick();
    head_valid = 1'b0;
    dn = 1'b0;
    for (int i = 0; i < 20 && !dn; i++) begin
      if (update_done) dn = 1'b1;
      else tick();
    end
    chk("ovr_done", dn, 1);
    chk("ovr_flag", overrun, 1);
    chk("ovr_len", length, 3);
    seg("ovr_s0", 3'd0, 10'd48, 10'd31);

    // reset mid-scan aborts the move
    do_reset();
    head_valid = 1'b1;
    head_x = 10'd48;
    head_y = 10'd31;
    tick();
    head_valid = 1'b0;
    tick();
    do_reset();
    chk("abort_busy", busy, 0);
    seg("abort_s0", 3'd0, 10'd47, 10'd31);

    // out-of-field head
    do_reset();
    move(10'd96, 10'd10, bn, dn);
    chk("oob_done", dn, 1);
`ifdef SNAKE_BOUNDS_CHECK_EN
    chk("oob_busy", bn, 0);
    chk("oob_coll", collision, 1);
    chk("oob_len", length, 3);
    seg("oob_s0", 3'd0, 10'd47, 10'd31);
`else
    chk("oob_busy", bn, 3);
    chk("oob_coll", collision, 0);
    seg("oob_s0", 3'd0, 10'd96, 10'd10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
